cnu_c2v_emitter: RTL and testbench

Check-node output stage placed directly downstream of the min-finder (`cnu_min_8` / `cnu_min_6` and their `opt_` variants). It latches one check node's compressed state: min1, min2, min_index and the per-edge sign bits. It then streams the `CN_DEGREE` check-to-variable (C2V) messages one per beat over a valid/ready handshake. Each magnitude is offset-corrected and saturated; each sign is the parity of all other edge signs.

---
 rtl/cnu_c2v_emitter_pkg.sv | 18 +
 rtl/cnu_c2v_emitter_offset_sat.sv | 22 ++
 rtl/cnu_c2v_emitter.sv | 107 ++++++++++
 tb/tb_cnu_c2v_emitter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnu_c2v_emitter_pkg.sv
// Shared constants and encodings for the check-node C2V emitter.
// A C2V message is {sign, magnitude}, with the sign bit at the MSB.
package cnu_c2v_emitter_pkg;

  localparam int DEF_QUAN_SIZE = 4;
  localparam int DEF_CN_DEGREE = 8;
  localparam int DEF_IDX_W     = 3;
  localparam int DEF_OFFSET    = 0;

  // Bit position of the sign within a C2V message of default width.
  localparam int MSG_SIGN_POS  = DEF_QUAN_SIZE;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } emit_state_e;

endpackage

// File: rtl/cnu_c2v_emitter_offset_sat.sv
// Offset-min-sum correction: subtracts OFFSET from a magnitude and clamps at zero.
// Purely combinational so the variable-node side can reuse it.
module cnu_offset_sat #(
  parameter int QUAN_SIZE = 4,
  parameter int OFFSET    = 0
) (
  input  logic [QUAN_SIZE-1:0] sel_mag,
  output logic [QUAN_SIZE-1:0] sat_mag
);

  // One extra bit holds the borrow; an offset beyond the range always borrows.
  localparam logic [QUAN_SIZE:0] OFF_EXT =
    (OFFSET >= (1 << QUAN_SIZE)) ? {1'b1, {QUAN_SIZE{1'b0}}} : (QUAN_SIZE+1)'(OFFSET);

  logic [QUAN_SIZE:0] diff;

  always_comb begin
    diff    = {1'b0, sel_mag} - OFF_EXT;
    sat_mag = diff[QUAN_SIZE] ? '0 : diff[QUAN_SIZE-1:0];
  end

endmodule

// File: rtl/cnu_c2v_emitter.sv
// Latches one check node's compressed state (min1, min2, min index, signs) and
// streams CN_DEGREE offset-corrected C2V messages, one per beat.
module cnu_c2v_emitter
  import cnu_c2v_emitter_pkg::*;
#(
  parameter int QUAN_SIZE = DEF_QUAN_SIZE,
  parameter int CN_DEGREE = DEF_CN_DEGREE,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int OFFSET    = DEF_OFFSET
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [QUAN_SIZE-1:0] in_min1,
  input  logic [QUAN_SIZE-1:0] in_min2,
  input  logic [IDX_W-1:0]     in_min_index,
  input  logic [CN_DEGREE-1:0] in_signs,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QUAN_SIZE:0]   out_msg,
  output logic [IDX_W-1:0]     out_edge,
  output logic                 out_last,
  output logic                 err_index
);

  // Handshake: a transfer happens on a rising sys_clk edge where valid && ready.
  // out_* hold while out_valid && !out_ready; in_ready may rise combinationally
  // from out_ready on the last beat so the next CN follows without a bubble.

  emit_state_e state, state_next;

  logic [QUAN_SIZE-1:0] min1_q, min2_q;
  logic [IDX_W-1:0]     idx_q, edge_q;
  logic [CN_DEGREE-1:0] signs_q;
  logic                 total_sign_q;
  logic                 err_q;

  logic                 last_beat, beat_done, accept, edge_sign;
  logic [QUAN_SIZE-1:0] sel_mag, sat_mag;

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = EMIT;
      EMIT:    if (out_ready && last_beat && !in_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == EMIT);
    last_beat = (edge_q == IDX_W'(CN_DEGREE - 1));
    out_last  = out_valid && last_beat;
    in_ready  = (state == IDLE) || (out_last && out_ready);
    beat_done = out_valid && out_ready;
    accept    = in_valid && in_ready;
    out_edge  = edge_q;
    err_index = err_q;

    // An out-of-range index never equals a live edge, so every edge gets min1.
    sel_mag   = (edge_q == idx_q) ? min2_q : min1_q;
    edge_sign = 1'b0;
    for (int i = 0; i < CN_DEGREE; i++) begin
      if (edge_q == IDX_W'(i)) edge_sign = signs_q[i];
    end
    out_msg   = out_valid ? {total_sign_q ^ edge_sign, sat_mag} : '0;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      min1_q       <= '0;
      min2_q       <= '0;
      idx_q        <= '0;
      signs_q      <= '0;
      total_sign_q <= 1'b0;
      edge_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        min1_q       <= in_min1;
        min2_q       <= in_min2;
        idx_q        <= in_min_index;
        signs_q      <= in_signs;
        total_sign_q <= ^in_signs;
        edge_q       <= '0;
        if (32'(in_min_index) >= 32'(CN_DEGREE)) err_q <= 1'b1;
      end else if (beat_done) begin
        edge_q <= last_beat ? '0 : edge_q + IDX_W'(1);
      end
    end
  end

  cnu_offset_sat #(
    .QUAN_SIZE (QUAN_SIZE),
    .OFFSET    (OFFSET)
  ) u_offset_sat (
    .sel_mag (sel_mag),
    .sat_mag (sat_mag)
  );

endmodule

// File: tb/tb_cnu_c2v_emitter.sv
// Directed bench for cnu_c2v_emitter: two instances (OFFSET 0 and 3) share stimulus;
// a vector table covers the data path, hand-written sequences cover handshake corners.
module tb_cnu_c2v_emitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [3:0] in_min1, in_min2, in_min_index;
  logic [7:0] in_signs;

  logic       in_ready0, out_valid0, out_last0, err0;
  logic [4:0] out_msg0;
  logic [3:0] out_edge0;
  logic       in_ready3, out_valid3, out_last3, err3;
  logic [4:0] out_msg3;
  logic [3:0] out_edge3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  min1;
    logic [3:0]  min2;
    logic [3:0]  idx;
    logic [7:0]  signs;
    logic [31:0] mag0;   // expected magnitude per edge, nibble e = edge e, OFFSET 0
    logic [31:0] mag3;   // same for OFFSET 3
    logic [7:0]  sgn;    // expected sign per edge
  } vec_t;

  vec_t tbl[5];
  vec_t ve;

  always #5 clk = ~clk;

  cnu_c2v_emitter #(.QUAN_SIZE(4), .CN_DEGREE(8), .IDX_W(4), .OFFSET(0)) dut0 (
    .sys_clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_min1(in_min1), .in_min2(in_min2), .in_min_index(in_min_index), .in_signs(in_signs),
    .out_valid(out_valid0), .out_ready(out_ready), .out_msg(out_msg0),
    .out_edge(out_edge0), .out_last(out_last0), .err_index(err0)
  );

  cnu_c2v_emitter #(.QUAN_SIZE(4), .CN_DEGREE(8), .IDX_W(4), .OFFSET(3)) dut3 (
    .sys_clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_min1(in_min1), .in_min2(in_min2), .in_min_index(in_min_index), .in_signs(in_signs),
    .out_valid(out_valid3), .out_ready(out_ready), .out_msg(out_msg3),
    .out_edge(out_edge3), .out_last(out_last3), .err_index(err3)
  );

  function automatic vec_t mk(logic [3:0] m1, logic [3:0] m2, logic [3:0] ix, logic [7:0] sg,
                              logic [31:0] g0, logic [31:0] g3, logic [7:0] es);
    vec_t v;
    v.min1 = m1; v.min2 = m2; v.idx = ix; v.signs = sg;
    v.mag0 = g0; v.mag3 = g3; v.sgn = es;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    in_valid     = 1'b1;
    in_min1      = v.min1;
    in_min2      = v.min2;
    in_min_index = v.idx;
    in_signs     = v.signs;
  endtask

  task automatic check_beat(int e, vec_t v, logic exp_err, string tag);
    logic [3:0] m0, m3;
    logic       s;
    logic [3:0] ee;
    m0 = v.mag0[4*e +: 4];
    m3 = v.mag3[4*e +: 4];
    s  = v.sgn[e];
    ee = e[3:0];
    chk($sformatf("%s valid0 e%0d", tag, e), 32'(out_valid0), 32'd1);
    chk($sformatf("%s valid3 e%0d", tag, e), 32'(out_valid3), 32'd1);
    chk($sformatf("%s edge e%0d", tag, e), 32'(out_edge0), 32'(ee));
    chk($sformatf("%s last e%0d", tag, e), 32'(out_last0), 32'(e == 7));
    chk($sformatf("%s msg0 e%0d", tag, e), 32'(out_msg0), 32'({s, m0}));
    chk($sformatf("%s msg3 e%0d", tag, e), 32'(out_msg3), 32'({s, m3}));
    chk($sformatf("%s err e%0d", tag, e), 32'(err0), 32'(exp_err));
  endtask

  // One isolated CN: accept from IDLE, then 8 beats with out_ready held high.
  task automatic run_cn(vec_t v, logic exp_err, string tag);
    @(negedge clk);
    drive(v);
    out_ready = 1'b1;
    #1;
    chk({tag, " in_ready idle"}, 32'(in_ready0), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int e = 0; e < 8; e++) begin
      check_beat(e, v, exp_err, tag);
      @(negedge clk);
    end
    chk({tag, " idle after"}, 32'(out_valid0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(4'd2,  4'd5,  4'd3, 8'b0000_0101, 32'h2222_5222, 32'h0000_2000, 8'b0000_0101);
    tbl[1] = mk(4'd2,  4'd5,  4'd0, 8'b0000_0000, 32'h2222_2225, 32'h0000_0002, 8'b0000_0000);
    tbl[2] = mk(4'd7,  4'd9,  4'd7, 8'b1000_0000, 32'h9777_7777, 32'h6444_4444, 8'b0111_1111);
    tbl[3] = mk(4'd0,  4'd15, 4'd5, 8'b1111_0000, 32'h00F0_0000, 32'h00C0_0000, 8'b1111_0000);
    tbl[4] = mk(4'd15, 4'd3,  4'd1, 8'b0110_1011, 32'hFFFF_FF3F, 32'hCCCC_CC0C, 8'b1001_0100);
    ve     = mk(4'd6,  4'd1,  4'd9, 8'b0000_0011, 32'h6666_6666, 32'h3333_3333, 8'b0000_0011);

    // Clock/reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_min1 = '0; in_min2 = '0; in_min_index = '0; in_signs = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid0), 32'd0);
    chk("rst out_msg",   32'(out_msg0),   32'd0);
    chk("rst out_edge",  32'(out_edge0),  32'd0);
    chk("rst out_last",  32'(out_last0),  32'd0);
    chk("rst err_index", 32'(err0),       32'd0);
    chk("rst in_ready",  32'(in_ready0),  32'd1);

    // Table-driven vectors
    for (int k = 0; k < 5; k++) run_cn(tbl[k], 1'b0, $sformatf("vec%0d", k));

    // Back-to-back: second CN held on the inputs while the first streams out
    @(negedge clk);
    drive(tbl[0]);
    out_ready = 1'b1;
    @(negedge clk);
    drive(tbl[2]);
    for (int e = 0; e < 8; e++) begin
      #1;
      check_beat(e, tbl[0], 1'b0, "b2b_a");
      chk($sformatf("b2b in_ready e%0d", e), 32'(in_ready0), 32'(e == 7));
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int e = 0; e < 8; e++) begin
      check_beat(e, tbl[2], 1'b0, "b2b_b");
      @(negedge clk);
    end
    chk("b2b idle after", 32'(out_valid0), 32'd0);

    // Stall on edge 4 and on the last edge, with a new CN waiting
    @(negedge clk);
    drive(tbl[1]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int e = 0; e < 4; e++) begin
      check_beat(e, tbl[1], 1'b0, "stall");
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    check_beat(4, tbl[1], 1'b0, "stall_hold0");
    @(negedge clk);
    check_beat(4, tbl[1], 1'b0, "stall_hold1");
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check_beat(4, tbl[1], 1'b0, "stall_release");
    @(negedge clk);
    for (int e = 5; e < 7; e++) begin
      check_beat(e, tbl[1], 1'b0, "stall");
      @(negedge clk);
    end
    out_ready = 1'b0;
    drive(tbl[3]);
    #1;
    check_beat(7, tbl[1], 1'b0, "last_stall");
    chk("last_stall in_ready", 32'(in_ready0), 32'd0);
    @(negedge clk);
    check_beat(7, tbl[1], 1'b0, "last_stall2");
    out_ready = 1'b1;
    #1;
    chk("last_release in_ready", 32'(in_ready0), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int e = 0; e < 8; e++) begin
      check_beat(e, tbl[3], 1'b0, "after_stall");
      @(negedge clk);
    end

    // Out-of-range min index: all edges get min1, error flag sticks
    run_cn(ve, 1'b1, "err");
    run_cn(tbl[0], 1'b1, "err_hold");

    // Reset in the middle of a CN
    @(negedge clk);
    drive(tbl[0]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      check_beat(e, tbl[0], 1'b1, "pre_rst");
      @(negedge clk);
    end
    check_beat(3, tbl[0], 1'b1, "pre_rst");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst out_valid", 32'(out_valid0), 32'd0);
    chk("mid_rst in_ready",  32'(in_ready0),  32'd1);
    chk("mid_rst out_edge",  32'(out_edge0),  32'd0);
    chk("mid_rst out_msg",   32'(out_msg0),   32'd0);
    chk("mid_rst err_index", 32'(err0),       32'd0);
    run_cn(tbl[4], 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
